// File: rtl/vote_pkg.sv
// Shared types and helpers for the ballot tally block.
package vote_pkg;

  // Session phases: waiting for a start, accepting ballots, presenting the result.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    RESULT  = 2'd2
  } state_t;

  // Bits needed to hold a population count of an n-bit word (0..n inclusive).
  function automatic int popcount_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/popcount_onehot.sv
// Combinational population count of an N-bit word, plus a one-hot decode of that count.
module popcount_onehot
  import vote_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [N-1:0]                   i_vec,
  output logic [popcount_width(N)-1:0]   o_count,
  output logic [N:0]                     o_onehot
);

  localparam int CW = popcount_width(N);
  localparam logic [N:0] ONE_HOT_BASE = {{N{1'b0}}, 1'b1};

  // Sum the set bits of the input word.
  always_comb begin
    o_count = '0;
    for (int i = 0; i < N; i++) begin
      o_count = o_count + CW'(i_vec[i]);
    end
  end

  // Bit k of the one-hot output is set where k equals the count.
  always_comb begin
    o_onehot = ONE_HOT_BASE << o_count;
  end

endmodule

// File: rtl/vote_tally.sv
// Session-based ballot accumulator: counts yes/no votes across up to MAX_BALLOTS
// ballot words and reports majority/tie once the session closes.
module vote_tally
  import vote_pkg::*;
#(
  parameter  int N_VOTERS    = 8,
  parameter  int MAX_BALLOTS = 15,
  localparam int CNT_W       = $clog2(N_VOTERS * MAX_BALLOTS + 1),
  localparam int BAL_W       = $clog2(MAX_BALLOTS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                ballot_valid,
  input  logic [N_VOTERS-1:0] ballot,
  output logic                ballot_ready,
  input  logic                close,
  input  logic                result_ack,
  output logic [N_VOTERS:0]   last_onehot,
  output logic [CNT_W-1:0]    yes_total,
  output logic [CNT_W-1:0]    no_total,
  output logic [BAL_W-1:0]    ballots_taken,
  output logic                result_valid,
  output logic                majority_yes,
  output logic                tie
);

  localparam int PC_W = popcount_width(N_VOTERS);

  state_t                r_state;
  logic [CNT_W-1:0]      r_yes;
  logic [CNT_W-1:0]      r_no;
  logic [BAL_W-1:0]      r_bal;
  logic [N_VOTERS:0]     r_last;
  logic                  r_result_valid;
  logic                  r_maj;
  logic                  r_tie;

  state_t                w_state_nxt;
  logic [CNT_W-1:0]      w_yes_nxt;
  logic [CNT_W-1:0]      w_no_nxt;
  logic [BAL_W-1:0]      w_bal_nxt;
  logic [N_VOTERS:0]     w_last_nxt;
  logic                  w_maj_nxt;
  logic                  w_tie_nxt;
  logic [PC_W-1:0]       w_cnt;
  logic [N_VOTERS:0]     w_onehot;
  logic                  w_accept;
  logic                  w_full_after;

  popcount_onehot #(
    .N (N_VOTERS)
  ) u_popcount (
    .i_vec    (ballot),
    .o_count  (w_cnt),
    .o_onehot (w_onehot)
  );

  // Ready depends only on registered state so it never loops back through ballot_valid.
  assign ballot_ready = (r_state == COLLECT) && (r_bal < BAL_W'(MAX_BALLOTS));
  assign w_accept     = ballot_valid && ballot_ready;
  // This accept fills the last free ballot slot of the session.
  assign w_full_after = w_accept && (r_bal == BAL_W'(MAX_BALLOTS - 1));

  // Next-state and datapath decode; verdict flags are computed from the post-accept
  // totals so a ballot arriving with close is included in the result.
  always_comb begin
    w_state_nxt = r_state;
    w_yes_nxt   = r_yes;
    w_no_nxt    = r_no;
    w_bal_nxt   = r_bal;
    w_last_nxt  = r_last;
    w_maj_nxt   = r_maj;
    w_tie_nxt   = r_tie;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = COLLECT;
          w_yes_nxt   = '0;
          w_no_nxt    = '0;
          w_bal_nxt   = '0;
          w_last_nxt  = '0;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      COLLECT: begin
        if (w_accept) begin
          w_yes_nxt  = r_yes + CNT_W'(w_cnt);
          w_no_nxt   = r_no + (CNT_W'(N_VOTERS) - CNT_W'(w_cnt));
          w_bal_nxt  = r_bal + BAL_W'(1);
          w_last_nxt = w_onehot;
        end else begin
          w_bal_nxt  = r_bal;
        end
        if (close || w_full_after) begin
          w_state_nxt = RESULT;
          w_maj_nxt   = (w_yes_nxt > w_no_nxt);
          w_tie_nxt   = (w_yes_nxt == w_no_nxt);
        end else begin
          w_state_nxt = COLLECT;
        end
      end
      RESULT: begin
        if (result_ack) begin
          w_state_nxt = IDLE;
          w_maj_nxt   = 1'b0;
          w_tie_nxt   = 1'b0;
        end else begin
          w_state_nxt = RESULT;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_maj_nxt   = 1'b0;
        w_tie_nxt   = 1'b0;
      end
    endcase
  end

  // State, accumulators and verdict registers; reset clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_yes          <= '0;
      r_no           <= '0;
      r_bal          <= '0;
      r_last         <= '0;
      r_result_valid <= 1'b0;
      r_maj          <= 1'b0;
      r_tie          <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_yes          <= w_yes_nxt;
      r_no           <= w_no_nxt;
      r_bal          <= w_bal_nxt;
      r_last         <= w_last_nxt;
      r_result_valid <= (w_state_nxt == RESULT);
      r_maj          <= w_maj_nxt;
      r_tie          <= w_tie_nxt;
    end
  end

  assign yes_total     = r_yes;
  assign no_total      = r_no;
  assign ballots_taken = r_bal;
  assign last_onehot   = r_last;
  assign result_valid  = r_result_valid;
  assign majority_yes  = r_maj;
  assign tie           = r_tie;

endmodule

// File: tb/tb_vote_tally.sv
// Self-checking bench for vote_tally (N_VOTERS=8, MAX_BALLOTS=15): directed
// scenarios plus randomized traffic, checked against a session-level reference model.
module tb_vote_tally;

  localparam int NV   = 8;
  localparam int MAXB = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          ballot_valid = 1'b0;
  logic [NV-1:0] ballot = '0;
  logic          ballot_ready;
  logic          close = 1'b0;
  logic          result_ack = 1'b0;
  logic [NV:0]   last_onehot;
  logic [6:0]    yes_total;
  logic [6:0]    no_total;
  logic [3:0]    ballots_taken;
  logic          result_valid;
  logic          majority_yes;
  logic          tie;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: session phase plus the list of ballots accepted this session.
  int         m_phase = 0;   // 0 idle, 1 collecting, 2 result shown
  bit         m_known = 1'b0;
  logic [7:0] m_ballots[$];
  int         m_maj = 0;
  int         m_tie = 0;

  vote_tally #(
    .N_VOTERS    (NV),
    .MAX_BALLOTS (MAXB)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .ballot_valid  (ballot_valid),
    .ballot        (ballot),
    .ballot_ready  (ballot_ready),
    .close         (close),
    .result_ack    (result_ack),
    .last_onehot   (last_onehot),
    .yes_total     (yes_total),
    .no_total      (no_total),
    .ballots_taken (ballots_taken),
    .result_valid  (result_valid),
    .majority_yes  (majority_yes),
    .tie           (tie)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int m_yes();
    int s = 0;
    foreach (m_ballots[i]) s += $countones(m_ballots[i]);
    return s;
  endfunction

  function automatic int m_no();
    return NV * m_ballots.size() - m_yes();
  endfunction

  function automatic logic [NV:0] m_last();
    logic [NV:0] v = '0;
    if (m_ballots.size() > 0) v[$countones(m_ballots[m_ballots.size()-1])] = 1'b1;
    return v;
  endfunction

  function automatic bit m_ready();
    return (m_phase == 1) && (m_ballots.size() < MAXB);
  endfunction

  // Apply one cycle of inputs, advance the model across the edge and compare outputs.
  task automatic cyc(input logic i_rst, input logic i_start, input logic i_bv,
                     input logic [7:0] i_b, input logic i_close, input logic i_ack);
    bit acc;
    rst = i_rst; start = i_start; ballot_valid = i_bv; ballot = i_b;
    close = i_close; result_ack = i_ack;
    #1;
    if (m_known) check_val("ballot_ready", 32'(ballot_ready), 32'(m_ready()));
    acc = i_bv && m_ready();
    @(posedge clk);
    if (i_rst) begin
      m_phase = 0; m_ballots.delete(); m_maj = 0; m_tie = 0; m_known = 1'b1;
    end else if (m_phase == 0) begin
      if (i_start) begin m_phase = 1; m_ballots.delete(); end
    end else if (m_phase == 1) begin
      if (acc) m_ballots.push_back(i_b);
      if (i_close || m_ballots.size() == MAXB) begin
        m_phase = 2;
        m_maj = (m_yes() > m_no()) ? 1 : 0;
        m_tie = (m_yes() == m_no()) ? 1 : 0;
      end
    end else begin
      if (i_ack) begin m_phase = 0; m_maj = 0; m_tie = 0; end
    end
    #1;
    if (m_known) begin
      check_val("yes_total", 32'(yes_total), 32'(m_yes()));
      check_val("no_total", 32'(no_total), 32'(m_no()));
      check_val("ballots_taken", 32'(ballots_taken), 32'(m_ballots.size()));
      check_val("last_onehot", 32'(last_onehot), 32'(m_last()));
      check_val("result_valid", 32'(result_valid), 32'(m_phase == 2));
      check_val("majority_yes", 32'(majority_yes), 32'(m_maj));
      check_val("tie", 32'(tie), 32'(m_tie));
    end
    @(negedge clk);
  endtask

  task automatic idle_cyc();
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    @(negedge clk);

    // Reset held two cycles with a ballot offered: everything zero, nothing accepted.
    cyc(1'b1, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0);
    check_val("rst_ready", 32'(ballot_ready), 32'd0);
    check_val("rst_yes", 32'(yes_total), 32'd0);
    check_val("rst_last", 32'(last_onehot), 32'd0);

    // Yes majority: FF, 0F, 01 then close.
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 8'h0F, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    check_val("maj_valid", 32'(result_valid), 32'd1);
    check_val("maj_yes", 32'(yes_total), 32'd13);
    check_val("maj_no", 32'(no_total), 32'd11);
    check_val("maj_flag", 32'(majority_yes), 32'd1);
    check_val("maj_tie", 32'(tie), 32'd0);
    check_val("maj_last", 32'(last_onehot), 32'h002);
    idle_cyc();
    // Start alongside ack in RESULT only returns to IDLE; totals persist.
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    check_val("ack_idle_valid", 32'(result_valid), 32'd0);
    check_val("ack_keep_yes", 32'(yes_total), 32'd13);

    // Tie with close coinciding with the second ballot.
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0);
    check_val("tie_yes", 32'(yes_total), 32'd8);
    check_val("tie_no", 32'(no_total), 32'd8);
    check_val("tie_flag", 32'(tie), 32'd1);
    check_val("tie_bal", 32'(ballots_taken), 32'd2);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    // Depth limit: 16 ballots offered back to back, only 15 counted.
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) cyc(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    check_val("full_no", 32'(no_total), 32'd120);
    check_val("full_yes", 32'(yes_total), 32'd0);
    check_val("full_bal", 32'(ballots_taken), 32'd15);
    check_val("full_valid", 32'(result_valid), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    // Empty session.
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    check_val("empty_tie", 32'(tie), 32'd1);
    check_val("empty_maj", 32'(majority_yes), 32'd0);
    check_val("empty_tot", 32'(yes_total + no_total), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    // Reset in the middle of a session, then a fresh session from zero.
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 8'h37, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 8'h80, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0);
    check_val("mid_rst_bal", 32'(ballots_taken), 32'd0);
    check_val("mid_rst_ready", 32'(ballot_ready), 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0);
    check_val("restart_yes", 32'(yes_total), 32'd2);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      cyc(($urandom_range(0, 99) == 0),
          ($urandom_range(0, 5) == 0),
          ($urandom_range(0, 2) != 0),
          8'($urandom),
          ($urandom_range(0, 19) == 0),
          ($urandom_range(0, 3) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vote_tally.md
VOTE_TALLY -- requirements
Module: vote_tally

Interface
REQ-001 SHALL have parameter N_VOTERS, default 8: number of voters per ballot word (range 2..32).
REQ-002 SHALL have parameter MAX_BALLOTS, default 15: ballots accepted per session (range 1..255).
REQ-003 SHALL derive localparam CNT_W = $clog2(N_VOTERS*MAX_BALLOTS+1) and BAL_W = $clog2(MAX_BALLOTS+1).
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 SHALL have the following ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  pulse that opens a session.
- ballot_valid  input  1  ballot present.
- ballot  input  N_VOTERS  one bit per voter (1 = yes, 0 = no).
- ballot_ready  output  1  ballot accepted this cycle when high together with ballot_valid.
- close  input  1  pulse that ends the session.
- result_ack  input  1  consumer has taken the result.
- last_onehot  output  N_VOTERS+1  bit k set, where k = yes-count of the last accepted ballot.
- yes_total  output  CNT_W  accumulated yes votes.
- no_total  output  CNT_W  accumulated no votes.
- ballots_taken  output  BAL_W  ballots accepted this session.
- result_valid  output  1  result fields are final.
- majority_yes  output  1  yes_total > no_total.
- tie  output  1  yes_total == no_total.

Function
REQ-006 SHALL implement an FSM with states IDLE, COLLECT and RESULT.
REQ-007 SHALL move from IDLE to COLLECT on start, clearing yes_total, no_total, ballots_taken and last_onehot in the same edge.
REQ-008 SHALL drive ballot_ready = (state==COLLECT) && (ballots_taken < MAX_BALLOTS), decoded combinationally from registered state only.
REQ-009 SHALL define accept = ballot_valid && ballot_ready, and on accept at edge t SHALL present the following from t+1 (latency 1):
- yes_total += popcount(ballot);
- no_total += N_VOTERS - popcount(ballot);
- ballots_taken += 1;
- last_onehot = onehot(popcount(ballot)).
REQ-010 SHALL move from COLLECT to RESULT on close, or on the edge where ballots_taken reaches MAX_BALLOTS.
REQ-011 SHALL, when close and an accepted ballot coincide, count that ballot before entering RESULT.
REQ-012 SHALL assert result_valid exactly while in RESULT, i.e. from the cycle after the closing edge.
REQ-013 SHALL hold majority_yes and tie registered and stable while in RESULT, and drive both to 0 outside RESULT.
REQ-014 SHALL, for a session closed with zero ballots, give totals 0, tie=1 and majority_yes=0.
REQ-015 SHALL hold RESULT until result_ack, then return to IDLE; totals SHALL persist until the next start.
REQ-016 SHALL ignore start in COLLECT and RESULT; start and result_ack together in RESULT SHALL go to IDLE only.
REQ-017 SHALL ignore close and result_ack outside COLLECT and RESULT respectively.
REQ-018 SHALL never wrap the accumulators: by construction, CNT_W holds N_VOTERS*MAX_BALLOTS.

Reset
REQ-019 SHALL, on rst at a clk edge, enter IDLE and clear every register; all outputs SHALL be 0 from the next cycle, including ballot_ready and last_onehot.
REQ-020 SHALL give rst priority over every other input, including in mid-COLLECT and in RESULT.

Structure
REQ-021 SHALL place the state enum (IDLE/COLLECT/RESULT) and a popcount width function in package vote_pkg.
REQ-022 SHALL instantiate one sub-module popcount_onehot (parameter N; combinational N-bit to count and (N+1)-bit one-hot), the parametrised generalisation of the fixed 3-voter counter.
REQ-023 SHALL register all outputs except ballot_ready.

Verification (N_VOTERS=8, MAX_BALLOTS=15)
REQ-024 SHALL cover reset: rst high for 2 cycles -> all outputs 0, ballot_ready 0, ballot_valid ignored.
REQ-025 SHALL cover a yes majority: start, ballots 8'hFF, 8'h0F, 8'h01, then close -> result_valid the cycle after close, yes_total=13, no_total=11, majority_yes=1, tie=0, last_onehot=9'h002.
REQ-026 SHALL cover a tie with a simultaneous close: start, 8'h00, then 8'hFF with close in the same cycle -> yes_total=8, no_total=8, tie=1, ballots_taken=2.
REQ-027 SHALL cover the depth limit: start, 16 consecutive 8'h00 with ballot_valid held -> ballot_ready low after the 15th, auto RESULT, no_total=120, yes_total=0, 16th ballot not counted.
REQ-028 SHALL cover an empty session: start then close -> tie=1, majority_yes=0, totals 0.
REQ-029 SHALL cover reset mid-session: rst after 3 ballots in COLLECT -> IDLE and all outputs 0 the next cycle; a subsequent start begins from zero totals.
